// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_ctrl_pkg                                          |
// | Description : Shared widths, state encoding and address helper for the     |
// |               memory-stage to 16-bit SRAM sequencing controller.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mem_access_ctrl_pkg;

  localparam int ADDRESS_LEN       = 32;
  localparam int WORD_LEN          = 32;
  localparam int SRAM_DATA_LEN     = 16;
  localparam int SRAM_ADDR_LEN_DEF = 18;

  // IDLE -> LO -> HI -> DONE -> IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Byte address relative to the SRAM window, converted to a 32-bit word index.
  // Callers truncate the result to the SRAM word width (modulo wrap).
  function automatic logic [ADDRESS_LEN-1:0] word_index(
    input logic [ADDRESS_LEN-1:0] byte_addr,
    input logic [ADDRESS_LEN-1:0] base_addr
  );
    return (byte_addr - base_addr) >> 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_wait_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_wait_counter                                             |
// | Description : 4-bit wait-state counter for one SRAM half-access.           |
// |               clr has priority over en; tc flags count == WAIT_CYCLES-1.   |
// | Ports       : clk, rst (async, active-low), clr, en -> tc                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_wait_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else if (clr) begin
      count <= 4'd0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign tc = (count == 4'(WAIT_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_ctrl                                              |
// | Description : Splits 32-bit memory-stage reads/writes into two 16-bit      |
// |               SRAM accesses (low half then high half), each lasting        |
// |               WAIT_CYCLES cycles; ready low freezes the pipeline.          |
// | Ports       : clk, rst (async, active-low)                                 |
// |               MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm  - request side          |
// |               rdata, ready                         - response side         |
// |               sram_addr, sram_dq_out, sram_dq_in,                          |
// |               sram_dq_oe, sram_we_n                - SRAM pins             |
// | Config      : MEM_CTRL_POSTED_WRITE_EN - writes release the pipeline in    |
// |               the accepting cycle and complete in the background.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int                     WAIT_CYCLES   = 3,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR     = 32'd1024,
  parameter int                     SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     MEM_R_EN,
  input  logic                     MEM_W_EN,
  input  logic [ADDRESS_LEN-1:0]   ALU_Res,
  input  logic [WORD_LEN-1:0]      Val_Rm,
  output logic [WORD_LEN-1:0]      rdata,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
);

  state_t                   state, state_nxt;
  logic [SRAM_ADDR_LEN-2:0] word_q;
  logic [WORD_LEN-1:0]      wdata_q;
  logic                     is_wr_q;
  logic                     req;
  logic                     in_phase;
  logic                     cnt_clr, cnt_en, cnt_tc;
`ifdef MEM_CTRL_POSTED_WRITE_EN
  logic                     posted_q;
`endif

  assign req      = MEM_R_EN | MEM_W_EN;
  assign in_phase = (state == ST_LO) || (state == ST_HI);

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_counter (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      rdata   <= '0;
`ifdef MEM_CTRL_POSTED_WRITE_EN
      posted_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        word_q  <= (SRAM_ADDR_LEN-1)'(word_index(ALU_Res, BASE_ADDR));
        wdata_q <= Val_Rm;
        is_wr_q <= MEM_W_EN;  // write wins when both enables are high
`ifdef MEM_CTRL_POSTED_WRITE_EN
        posted_q <= MEM_W_EN;
`endif
      end
      // Each half is sampled on the final (hold) cycle of its phase.
      if (!is_wr_q && cnt_tc) begin
        if (state == ST_LO) rdata[15:0]  <= sram_dq_in;
        if (state == ST_HI) rdata[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    ready     = 1'b0;
    case (state)
      ST_IDLE: if (req) state_nxt = ST_LO;
      ST_LO: begin
        cnt_en  = 1'b1;
        cnt_clr = cnt_tc;  // restart the count for the next phase
        if (cnt_tc) state_nxt = ST_HI;
      end
      ST_HI: begin
        cnt_en  = 1'b1;
        cnt_clr = cnt_tc;
        if (cnt_tc) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

`ifdef MEM_CTRL_POSTED_WRITE_EN
    // A posted write frees the pipeline immediately; any request arriving
    // before it drains waits and is accepted from IDLE afterwards.
    case (state)
      ST_IDLE: ready = !req || MEM_W_EN;
      ST_DONE: ready = posted_q ? !req : 1'b1;
      default: ready = posted_q && !req;
    endcase
`else
    ready = ((state == ST_IDLE) && !req) || (state == ST_DONE);
`endif
  end

  // Pin drive decoded from state; the last cycle of a write phase keeps
  // address/data stable with the strobe released.
  assign sram_addr   = in_phase ? {word_q, (state == ST_HI)} : '0;
  assign sram_dq_out = (in_phase && is_wr_q) ?
                       ((state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0]) : '0;
  assign sram_dq_oe  = in_phase && is_wr_q;
  assign sram_we_n   = !(in_phase && is_wr_q && !cnt_tc);

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_ctrl                                           |
// | Description : Scoreboard bench for mem_access_ctrl (blocking-write build). |
// |               A word-level reference memory predicts every response; a     |
// |               monitor compares on each ready, and a half-word SRAM model   |
// |               sits on the pins.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_ctrl;

  localparam int          WAIT_CYCLES   = 3;
  localparam int          SRAM_ADDR_LEN = 18;
  localparam int          LATENCY       = 2 * WAIT_CYCLES + 1;
  localparam logic [31:0] BASE          = 32'd1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_r_en, mem_w_en;
  logic [31:0] alu_res, val_rm, rdata;
  logic        ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .WAIT_CYCLES  (WAIT_CYCLES),
    .BASE_ADDR    (BASE),
    .SRAM_ADDR_LEN(SRAM_ADDR_LEN)
  ) dut (
    .clk        (clk),
    .rst        (rst_n),
    .MEM_R_EN   (mem_r_en),
    .MEM_W_EN   (mem_w_en),
    .ALU_Res    (alu_res),
    .Val_Rm     (val_rm),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
  );

  // ---------------- SRAM pin model (16-bit half-words) ----------------
  logic [15:0] sram[int];

  function automatic logic [15:0] sram_rd(input int a);
    return sram.exists(a) ? sram[a] : 16'h0000;
  endfunction

  always @(posedge clk)
    if (rst_n && !sram_we_n && sram_dq_oe) sram[int'(sram_addr)] = sram_dq_out;

  // Address is stable for a whole phase, so a mid-cycle refresh is enough.
  always @(negedge clk) sram_dq_in = sram_rd(int'(sram_addr));

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int          issue;
    bit          wr;
    int          word;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } item_t;

  item_t       q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] last_rd = 32'h0;
  int          errors = 0, checks = 0, cyc = 0;
  bit          mon_en = 1'b0;
  int          we_lo_cnt = 0, oe_cnt = 0;

  always @(posedge clk) cyc++;

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return int'(off % (32'd1 << (SRAM_ADDR_LEN - 1)));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops on every ready while an access is outstanding.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        if (!sram_we_n) we_lo_cnt++;
        if (sram_dq_oe) oe_cnt++;
        if (ready) begin
          item_t it;
          it = q.pop_front();
          chk("latency", 32'(cyc - it.issue), 32'(LATENCY));
          chk("rdata", rdata, it.exp_rd);
          if (it.wr) begin
            chk("sram_lo", {16'h0, sram_rd(it.word * 2)},     {16'h0, it.wdata[15:0]});
            chk("sram_hi", {16'h0, sram_rd(it.word * 2 + 1)}, {16'h0, it.wdata[31:16]});
            chk("we_low_cycles", 32'(we_lo_cnt), 32'(2 * (WAIT_CYCLES - 1)));
            chk("wr_oe_cycles", 32'(oe_cnt), 32'(2 * WAIT_CYCLES));
          end else begin
            chk("rd_we_low", 32'(we_lo_cnt), 32'd0);
            chk("rd_oe", 32'(oe_cnt), 32'd0);
          end
          we_lo_cnt = 0;
          oe_cnt    = 0;
        end else if (cyc - q[0].issue > 4 * LATENCY) begin
          chk("ready_timeout", 32'd0, 32'd1);
          void'(q.pop_front());
          we_lo_cnt = 0;
          oe_cnt    = 0;
        end
      end else begin
        chk("idle_pins", {29'h0, ready, sram_we_n, sram_dq_oe}, 32'b110);
      end
    end
  end

  // Issue one request, predict its response, and wait for the monitor to retire it.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    item_t it;
    @(posedge clk);
    #1;
    mem_r_en = rd;
    mem_w_en = wr;
    alu_res  = addr;
    val_rm   = data;
    it.issue = cyc;
    it.wr    = wr;
    it.word  = word_of(addr);
    it.wdata = data;
    if (wr) begin
      ref_mem[it.word] = data;
      it.exp_rd = last_rd;
    end else begin
      it.exp_rd = ref_mem.exists(it.word) ? ref_mem[it.word] : 32'h0;
      last_rd   = it.exp_rd;
    end
    q.push_back(it);
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    if (q.size() != 0) begin
      chk("driver_timeout", 32'd0, 32'd1);
      q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    alu_res  = 32'h0;
    val_rm   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, ready}, 32'd1);
    chk("rst_we_n", {31'h0, sram_we_n}, 32'd1);
    chk("rst_oe", {31'h0, sram_dq_oe}, 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_dq_out", {16'h0, sram_dq_out}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);

    // Directed cases
    do_req(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'd1028, 32'h0);
    do_req(1'b1, 1'b1, 32'd1032, 32'h12345678);  // write wins
    do_req(1'b1, 1'b0, 32'd1032, 32'h0);
    do_req(1'b0, 1'b1, 32'd0,    32'hA5A55A5A);  // below base: wraps
    do_req(1'b1, 1'b0, 32'd0,    32'h0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          op;
      a  = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'(4 * $urandom_range(0, 31));
      op = $urandom_range(0, 4);
      do_req(op == 0 || op == 1 || op == 4, op == 2 || op == 3 || op == 4, a, $urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset during the high half of a write: only the low half lands.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    mem_w_en = 1'b1;
    alu_res  = BASE + 32'd400;
    val_rm   = 32'hCAFEF00D;
    repeat (WAIT_CYCLES + 1) @(posedge clk);
    #1;
    rst_n    = 1'b0;
    mem_w_en = 1'b0;
    #1;
    chk("midrst_ready", {31'h0, ready}, 32'd1);
    chk("midrst_we_n", {31'h0, sram_we_n}, 32'd1);
    chk("midrst_oe", {31'h0, sram_dq_oe}, 32'd0);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    chk("midrst_dq_out", {16'h0, sram_dq_out}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, ready}, 32'd1);
    chk("partial_lo", {16'h0, sram_rd(200)}, 32'h0000F00D);
    chk("partial_hi", {16'h0, sram_rd(201)}, 32'h00000000);
    ref_mem[100] = 32'h0000F00D;
    last_rd      = 32'h0;
    mon_en       = 1'b1;
    do_req(1'b1, 1'b0, BASE + 32'd400, 32'h0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
